// File: rtl/input_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : input_debounce                                                |
// | Purpose  : Synchronizes a raw asynchronous level into the clk domain and |
// |            debounces it. The clean output level only changes after the   |
// |            synchronized input has disagreed with it for DEBOUNCE_CYCLES  |
// |            consecutive samples. Drives the downstream edge-detect stage. |
// |                                                                          |
// | Parameters:                                                              |
// |   SYNC_STAGES     synchronizer depth (>= 2)                              |
// |   DEBOUNCE_CYCLES mismatching samples needed to flip out (>= 1)          |
// |   RESET_VALUE     reset level of the synchronizer chain and of out       |
// |                                                                          |
// | Ports:                                                                   |
// |   clk          in   1  sole clock, rising edge                           |
// |   rst_n        in   1  asynchronous active-low reset                     |
// |   in           in   1  raw asynchronous level                            |
// |   out          out  1  debounced level (flop output)                     |
// |   busy         out  1  high while a candidate transition is confirmed    |
// |   glitch_clr   in   1  clear glitch_count (optional)                     |
// |   glitch_count out  8  saturating count of aborted candidates (optional) |
// |                                                                          |
// | Optional feature macro: INPUT_DEBOUNCE_GLITCH_CNT_EN                     |
// |   When defined, adds glitch_clr / glitch_count and the abort counter.    |
// |                                                                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module input_debounce #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic RESET_VALUE     = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in,
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
  input  logic       glitch_clr,
  output logic [7:0] glitch_count,
`endif
  output logic       out,
  output logic       busy
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  // Count value at which the current mismatching sample is the last one needed.
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_STABLE  = 1'b0,
    ST_CONFIRM = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  state_t                 state_q, state_d;
  logic                   out_q, out_d;
  logic                   busy_q, busy_d;
  logic                   in_s;

  // Synchronized input: last stage of the chain. Nothing else looks at in.
  assign in_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], in};
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;

    case (state_q)
      ST_STABLE: begin
        cnt_d = '0;
        if (in_s != out_q) begin
          // A window of one sample needs no confirmation phase at all.
          if (DEBOUNCE_CYCLES == 1) begin
            out_d = in_s;
          end else begin
            state_d = ST_CONFIRM;
            cnt_d   = CNT_ONE;
          end
        end
      end
      ST_CONFIRM: begin
        if (in_s == out_q) begin
          // Bounce: the candidate is dropped, out keeps its level.
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          out_d   = in_s;
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase

    // busy is registered alongside the state so it tracks CONFIRM exactly.
    busy_d = (state_d == ST_CONFIRM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= {SYNC_STAGES{RESET_VALUE}};
      cnt_q   <= '0;
      state_q <= ST_STABLE;
      out_q   <= RESET_VALUE;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
    end
  end

  assign out  = out_q;
  assign busy = busy_q;

`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_count_q, glitch_count_d;
  logic       glitch_abort;

  // An abort is a CONFIRM cycle in which the input has fallen back to out.
  assign glitch_abort = (state_q == ST_CONFIRM) && (in_s == out_q);

  always_comb begin
    glitch_count_d = glitch_count_q;
    // Clear takes priority over a coincident abort.
    if (glitch_clr) begin
      glitch_count_d = 8'd0;
    end else if (glitch_abort && (glitch_count_q != 8'hFF)) begin
      glitch_count_d = glitch_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_count_q <= 8'd0;
    end else begin
      glitch_count_q <= glitch_count_d;
    end
  end

  assign glitch_count = glitch_count_q;
`else
  // Glitch counter not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_input_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_input_debounce                                             |
// | Purpose  : Directed self-checking bench for input_debounce. Instance A   |
// |            uses default parameters, instance B uses SYNC_STAGES=3 and    |
// |            DEBOUNCE_CYCLES=1.                                            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_input_debounce;

  logic clk = 1'b0;
  logic rst_n;
  logic in_a, out_a, busy_a;
  logic in_b, out_b, busy_b;
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
  logic       glitch_clr_a, glitch_clr_b;
  logic [7:0] glitch_count_a, glitch_count_b;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  input_debounce u_dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .in           (in_a),
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
    .glitch_clr   (glitch_clr_a),
    .glitch_count (glitch_count_a),
`endif
    .out          (out_a),
    .busy         (busy_a)
  );

  input_debounce #(
    .SYNC_STAGES     (3),
    .DEBOUNCE_CYCLES (1),
    .RESET_VALUE     (1'b0)
  ) u_dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .in           (in_b),
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
    .glitch_clr   (glitch_clr_b),
    .glitch_count (glitch_count_b),
`endif
    .out          (out_b),
    .busy         (busy_b)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs changed afterwards are sampled by the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One short pulse on in_a: the candidate is aborted on the sixth edge.
  task automatic do_glitch();
    in_a = 1'b1;
    repeat (3) tick();
    in_a = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    in_a  = 1'b1;
    in_b  = 1'b0;
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
    glitch_clr_a = 1'b0;
    glitch_clr_b = 1'b0;
`endif

    // Reset with in high: out stays at RESET_VALUE.
    repeat (3) tick();
    chk("rst_out_a",  out_a,  8'd0);
    chk("rst_busy_a", busy_a, 8'd0);
    chk("rst_out_b",  out_b,  8'd0);
    chk("rst_busy_b", busy_b, 8'd0);
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
    chk("rst_glitch", glitch_count_a, 8'd0);
`endif

    // Release with in low: out never moves.
    in_a  = 1'b0;
    rst_n = 1'b1;
    for (int t = 0; t < 100; t++) begin
      tick();
      chk("idle_out", out_a, 8'd0);
    end

    // Clean 0->1 step: out rises on edge k+17, busy high for 15 cycles before.
    in_a = 1'b1;
    for (int t = 1; t <= 18; t++) begin
      tick();
      chk("step_out",  out_a,  (t == 18) ? 8'd1 : 8'd0);
      chk("step_busy", busy_a, (t >= 3 && t <= 17) ? 8'd1 : 8'd0);
    end

    // Clean 1->0 step.
    in_a = 1'b0;
    repeat (17) tick();
    chk("fall_out_hold", out_a, 8'd1);
    tick();
    chk("fall_out", out_a, 8'd0);

    // Bounce every 5 cycles for 200 cycles: out must not move.
    for (int seg = 0; seg < 40; seg++) begin
      in_a = (seg % 2 == 0) ? 1'b1 : 1'b0;
      for (int t = 0; t < 5; t++) begin
        tick();
        chk("bounce_out", out_a, 8'd0);
      end
    end
    in_a = 1'b1;
    for (int t = 1; t <= 18; t++) begin
      tick();
      chk("settle_out", out_a, (t == 18) ? 8'd1 : 8'd0);
    end
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
    chk("bounce_glitches", glitch_count_a, 8'd20);
`endif

    // DEBOUNCE_CYCLES=1, SYNC_STAGES=3: one-cycle pulse reappears 3 edges later.
    in_b = 1'b1;
    tick();
    in_b = 1'b0;
    chk("pulse_out_b", out_b, 8'd0);
    for (int t = 2; t <= 6; t++) begin
      tick();
      chk("pulse_out_b",  out_b,  (t == 4) ? 8'd1 : 8'd0);
      chk("pulse_busy_b", busy_b, 8'd0);
    end

    // Reset in the middle of a 0->1 confirmation.
    in_a = 1'b0;
    repeat (18) tick();
    chk("pre_mid_out", out_a, 8'd0);
    in_a = 1'b1;
    repeat (10) tick();
    chk("mid_busy", busy_a, 8'd1);
    chk("mid_out",  out_a,  8'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy_a, 8'd0);
    chk("mid_rst_out",  out_a,  8'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int t = 1; t <= 18; t++) begin
      tick();
      chk("restart_out", out_a, (t == 18) ? 8'd1 : 8'd0);
      if (t == 3) chk("restart_busy", busy_a, 8'd1);
    end

`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
    chk("glitch_after_rst", glitch_count_a, 8'd0);
    // Back to a low stable level, then saturate the glitch counter.
    in_a = 1'b0;
    repeat (18) tick();
    chk("sat_pre_out", out_a, 8'd0);
    for (int n = 0; n < 300; n++) do_glitch();
    chk("glitch_sat", glitch_count_a, 8'd255);
    repeat (5) do_glitch();
    chk("glitch_hold", glitch_count_a, 8'd255);

    // Clear on the very cycle of an abort: clear wins.
    in_a = 1'b1;
    repeat (3) tick();
    in_a = 1'b0;
    repeat (2) tick();
    chk("clr_pre_busy", busy_a, 8'd1);
    glitch_clr_a = 1'b1;
    tick();
    glitch_clr_a = 1'b0;
    chk("clr_count", glitch_count_a, 8'd0);
    chk("clr_busy",  busy_a,        8'd0);
    do_glitch();
    chk("clr_then_inc", glitch_count_a, 8'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
